// File: rtl/mupiano_pkg.sv
// Shared types and tables for the MuPiano voice allocator.
// Holds the note type, event decode helper, scancode->note table and FSM states.
package mupiano_pkg;

    typedef logic [5:0] note_t;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam note_t      NOTE_NONE = 6'd0;

    typedef enum logic [1:0] {
        IDLE,
        LOOK,
        MATCH,
        COMMIT
    } state_t;

    typedef struct packed {
        logic       is_break;
        logic [7:0] code;
    } event_t;

    // Split a 16-bit key event into break flag and scancode.
    function automatic event_t decode_event(input logic [15:0] kv);
        event_t ev;
        ev.is_break = (kv[15:8] == SC_BREAK);
        ev.code     = kv[7:0];
        return ev;
    endfunction

    // Home row carries the white keys (A S D F G H J K L ; '),
    // the row above carries the black keys (W E T Y U O P).
    // Returns {valid, note}; note 0 is reserved for "no note".
    function automatic logic [6:0] scan_to_note(input logic [7:0] code);
        logic [6:0] r;
        case (code)
            8'h1C:   r = {1'b1, 6'd1};
            8'h1B:   r = {1'b1, 6'd2};
            8'h23:   r = {1'b1, 6'd3};
            8'h2B:   r = {1'b1, 6'd4};
            8'h34:   r = {1'b1, 6'd5};
            8'h33:   r = {1'b1, 6'd6};
            8'h3B:   r = {1'b1, 6'd7};
            8'h42:   r = {1'b1, 6'd8};
            8'h4B:   r = {1'b1, 6'd9};
            8'h4C:   r = {1'b1, 6'd10};
            8'h52:   r = {1'b1, 6'd11};
            8'h1D:   r = {1'b1, 6'd12};
            8'h24:   r = {1'b1, 6'd13};
            8'h2C:   r = {1'b1, 6'd14};
            8'h35:   r = {1'b1, 6'd15};
            8'h3C:   r = {1'b1, 6'd16};
            8'h44:   r = {1'b1, 6'd17};
            8'h4D:   r = {1'b1, 6'd18};
            default: r = {1'b0, NOTE_NONE};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/scan2note.sv
// Combinational scancode to note lookup.
module scan2note
    import mupiano_pkg::*;
(
    input  logic [7:0] code,
    output logic       valid,
    output note_t      note
);

    // Table lookup, no state.
    always_comb begin
        {valid, note} = scan_to_note(code);
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: maps key make/break events onto NVOICES voices.
// Build option VOICE_STEAL_EN: when defined, a make with every voice busy steals
// the oldest voice; when undefined, that make is discarded and `dropped` pulses.
module voice_allocator
    import mupiano_pkg::*;
#(
    parameter int NVOICES = 4,
    parameter int AGEW    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [15:0]            keycodev,
    input  logic                   start,
    output logic [NVOICES-1:0]     voice_gate,
    output logic [6*NVOICES-1:0]   voice_note,
    output logic [NVOICES-1:0]     voice_trig,
    output logic                   busy,
    output logic                   overrun,
    output logic                   dropped
);

    state_t              state;
    event_t              evt;
    event_t              pend;
    logic                pend_valid;
    note_t               ev_note;
    note_t               notes [NVOICES];
    logic [NVOICES-1:0]  hit;
    logic [NVOICES-1:0]  free;
    logic [NVOICES-1:0]  oldest;
    logic [NVOICES-1:0]  hit_c;
    logic [NVOICES-1:0]  free_c;
    logic [NVOICES-1:0]  oldest_c;
    logic [NVOICES-1:0]  choose;
    logic                lk_valid;
    note_t               lk_note;
    logic                fin;

    scan2note u_scan2note (
        .code  (evt.code),
        .valid (lk_valid),
        .note  (lk_note)
    );

    // The current event finishes in COMMIT, or early in LOOK when unmapped.
    assign fin = (state == COMMIT) || ((state == LOOK) && !lk_valid);

    // Lowest free voice wins; otherwise fall back to the oldest (zero when stealing is off).
    assign choose = (|free) ? (free & (~free + NVOICES'(1))) : oldest;

    // Per-voice hit and free vectors against the registered event note.
    always_comb begin
        hit_c  = '0;
        free_c = '0;
        for (int i = 0; i < NVOICES; i++) begin
            hit_c[i]  = voice_gate[i] && (notes[i] == ev_note);
            free_c[i] = !voice_gate[i];
        end
    end

`ifdef VOICE_STEAL_EN
    logic [AGEW-1:0] age [NVOICES];

    // One-hot of the oldest gated voice; strict compare keeps the lowest index on ties.
    always_comb begin
        logic [AGEW-1:0] best;
        logic            found;
        oldest_c = '0;
        best     = '0;
        found    = 1'b0;
        for (int i = 0; i < NVOICES; i++) begin
            if (voice_gate[i] && (!found || age[i] > best)) begin
                oldest_c    = '0;
                oldest_c[i] = 1'b1;
                best        = age[i];
                found       = 1'b1;
            end
        end
    end

    // Age bookkeeping: reset on assign/release, saturating increment for the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oldest <= '0;
            for (int i = 0; i < NVOICES; i++) age[i] <= '0;
        end else begin
            if (state == MATCH) oldest <= oldest_c;
            if (state == COMMIT) begin
                for (int i = 0; i < NVOICES; i++) begin
                    if (evt.is_break) begin
                        if (hit[i]) age[i] <= '0;
                    end else if ((hit == '0) && (choose != '0)) begin
                        if (choose[i])
                            age[i] <= '0;
                        else if (voice_gate[i] && (age[i] != '1))
                            age[i] <= age[i] + AGEW'(1);
                    end
                end
            end
        end
    end
`else
    // No ages are kept in this build, so there is never an oldest voice to steal.
    assign oldest_c = '0;
    assign oldest   = {NVOICES{AGEW < 1}};
`endif

    // Sequencer FSM, event/pending registers and voice state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            evt        <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
            ev_note    <= NOTE_NONE;
            hit        <= '0;
            free       <= '0;
            voice_gate <= '0;
            voice_trig <= '0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            dropped    <= 1'b0;
            for (int i = 0; i < NVOICES; i++) notes[i] <= NOTE_NONE;
        end else begin
            voice_trig <= '0;
            overrun    <= 1'b0;
            dropped    <= 1'b0;

            if (start && (state != IDLE)) begin
                if (pend_valid) begin
                    overrun <= 1'b1;
                end else if (!fin) begin
                    pend       <= decode_event(keycodev);
                    pend_valid <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        evt   <= decode_event(keycodev);
                        state <= LOOK;
                        busy  <= 1'b1;
                    end
                end
                LOOK: begin
                    ev_note <= lk_note;
                    if (lk_valid) state <= MATCH;
                end
                MATCH: begin
                    hit   <= hit_c;
                    free  <= free_c;
                    state <= COMMIT;
                end
                COMMIT: begin
                    if (evt.is_break) begin
                        for (int i = 0; i < NVOICES; i++) begin
                            if (hit[i]) begin
                                voice_gate[i] <= 1'b0;
                                notes[i]      <= NOTE_NONE;
                            end
                        end
                    end else if (hit == '0) begin
                        if (choose == '0) dropped <= 1'b1;
                        for (int i = 0; i < NVOICES; i++) begin
                            if (choose[i]) begin
                                voice_gate[i] <= 1'b1;
                                notes[i]      <= ev_note;
                                voice_trig[i] <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Chain straight into the next event when one is waiting.
            if (fin) begin
                if (pend_valid) begin
                    evt        <= pend;
                    pend_valid <= 1'b0;
                    state      <= LOOK;
                end else if (start) begin
                    evt   <= decode_event(keycodev);
                    state <= LOOK;
                end else begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            end
        end
    end

    // Flatten the note registers onto the output bus.
    always_comb begin
        voice_note = '0;
        for (int i = 0; i < NVOICES; i++) voice_note[6*i +: 6] = notes[i];
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator (NVOICES=4).
module tb_voice_allocator;

    localparam int NV = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [15:0]       keycodev;
    logic              start;
    logic [NV-1:0]     voice_gate;
    logic [6*NV-1:0]   voice_note;
    logic [NV-1:0]     voice_trig;
    logic              busy;
    logic              overrun;
    logic              dropped;

    voice_allocator #(.NVOICES(NV), .AGEW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .keycodev   (keycodev),
        .start      (start),
        .voice_gate (voice_gate),
        .voice_note (voice_note),
        .voice_trig (voice_trig),
        .busy       (busy),
        .overrun    (overrun),
        .dropped    (dropped)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] kc;
        logic [3:0]  gate;
        logic [23:0] note;
        logic [3:0]  trig;
        logic        drop;
        logic [4:0]  cyc;
    } vec_t;

    vec_t vecs [9];
    vec_t sb [$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        start    = 1'b0;
        keycodev = 16'h0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Drive one event, wait for busy to drop, compare against the scoreboard head.
    task automatic apply(input vec_t v, input string tag);
        vec_t       e;
        int         cyc;
        logic [3:0] trig_now;
        logic       drop_now;
        sb.push_back(v);
        @(negedge clk);
        keycodev = v.kc;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (busy && cyc < 20) begin
            cyc++;
            @(negedge clk);
        end
        trig_now = voice_trig;
        drop_now = dropped;
        e = sb.pop_front();
        check({tag, "_busy_cycles"}, cyc, e.cyc);
        check({tag, "_gate"}, voice_gate, e.gate);
        check({tag, "_note"}, voice_note, e.note);
        check({tag, "_trig"}, trig_now, e.trig);
        check({tag, "_dropped"}, drop_now, e.drop);
        @(negedge clk);
        check({tag, "_pulse_end"}, {voice_trig, dropped}, 5'd0);
    endtask

    initial begin
        vec_t e;
        int   ov_cnt;
        int   busy_cnt;
        int   trig_cnt;

        vecs[0] = '{16'h001C, 4'b0001, 24'h000001, 4'b0001, 1'b0, 5'd3};
        vecs[1] = '{16'h001B, 4'b0011, 24'h000081, 4'b0010, 1'b0, 5'd3};
        vecs[2] = '{16'h0023, 4'b0111, 24'h003081, 4'b0100, 1'b0, 5'd3};
        vecs[3] = '{16'hF01B, 4'b0101, 24'h003001, 4'b0000, 1'b0, 5'd3};
        vecs[4] = '{16'h001B, 4'b0111, 24'h003081, 4'b0010, 1'b0, 5'd3};
        vecs[5] = '{16'h002B, 4'b1111, 24'h103081, 4'b1000, 1'b0, 5'd3};
`ifdef VOICE_STEAL_EN
        vecs[6] = '{16'h0033, 4'b1111, 24'h103086, 4'b0001, 1'b0, 5'd3};
        vecs[7] = '{16'hF076, 4'b1111, 24'h103086, 4'b0000, 1'b0, 5'd1};
        vecs[8] = '{16'h0076, 4'b1111, 24'h103086, 4'b0000, 1'b0, 5'd1};
`else
        vecs[6] = '{16'h0033, 4'b1111, 24'h103081, 4'b0000, 1'b1, 5'd3};
        vecs[7] = '{16'hF076, 4'b1111, 24'h103081, 4'b0000, 1'b0, 5'd1};
        vecs[8] = '{16'h0076, 4'b1111, 24'h103081, 4'b0000, 1'b0, 5'd1};
`endif

        do_reset();
        check("reset_outputs", {voice_gate, voice_note, voice_trig, busy, overrun, dropped}, 32'd0);

        for (int i = 0; i < 9; i++) apply(vecs[i], $sformatf("vec%0d", i));

        // Typematic repeat: only the first make allocates and triggers.
        do_reset();
        apply('{16'h001C, 4'b0001, 24'h000001, 4'b0001, 1'b0, 5'd3}, "rep1");
        apply('{16'h001C, 4'b0001, 24'h000001, 4'b0000, 1'b0, 5'd3}, "rep2");
        apply('{16'h001C, 4'b0001, 24'h000001, 4'b0000, 1'b0, 5'd3}, "rep3");

        // Three starts back to back: first runs, second pends, third overruns.
        do_reset();
        sb.push_back('{16'h001C, 4'b0001, 24'h000001, 4'b0001, 1'b0, 5'd3});
        sb.push_back('{16'h001B, 4'b0011, 24'h000081, 4'b0010, 1'b0, 5'd3});
        ov_cnt   = 0;
        busy_cnt = 0;
        trig_cnt = 0;
        @(negedge clk);
        keycodev = 16'h001C;
        start    = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (c == 0)      keycodev = 16'h001B;
            else if (c == 1) keycodev = 16'h0023;
            else             start = 1'b0;
            if (c == 2) check("burst_overrun_at_third", overrun, 1);
            ov_cnt   += int'(overrun);
            busy_cnt += int'(busy);
            if (voice_trig != '0) begin
                trig_cnt++;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check($sformatf("burst%0d_gate", trig_cnt), voice_gate, e.gate);
                    check($sformatf("burst%0d_note", trig_cnt), voice_note, e.note);
                    check($sformatf("burst%0d_trig", trig_cnt), voice_trig, e.trig);
                end
            end
        end
        check("burst_overrun_count", ov_cnt, 1);
        check("burst_busy_cycles", busy_cnt, 6);
        check("burst_trig_count", trig_cnt, 2);
        check("burst_scoreboard_empty", sb.size(), 0);
        check("burst_final_gate", voice_gate, 4'b0011);

        // Asynchronous reset while an event sits in MATCH.
        do_reset();
        apply('{16'h001C, 4'b0001, 24'h000001, 4'b0001, 1'b0, 5'd3}, "pre_rst");
        @(negedge clk);
        keycodev = 16'h001B;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("mid_busy_before_rst", busy, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_outputs", {voice_gate, voice_note, voice_trig, busy, overrun, dropped}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        apply('{16'h0023, 4'b0001, 24'h000003, 4'b0001, 1'b0, 5'd3}, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
